// File: rtl/axi_rd_arb_if.sv
// axi_rd_arb_if: AXI read-address and read-data channels for one port
interface axi_rd_arb_if;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast, rid
   );
   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: two-requester AXI read arbiter with one outstanding burst,
// fixed priority with starvation relief (PRIO0=1) or round-robin (PRIO0=0).
module axi_rd_arb #(
   parameter bit PRIO0   = 1'b1,
   parameter int MAXWAIT = 4
) (
   input  logic         clock,
   input  logic         reset,
   axi_rd_arb_if.slave  s0,
   axi_rd_arb_if.slave  s1,
   axi_rd_arb_if.master m,
   output logic         grant,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t state, state_nx;
   logic grant_q, last_q, req, win1, in_idle, in_addr, in_data, own_rready, s0_own, s1_own;
   logic [2:0] starve;
   logic [31:0] addr_q;
   logic [3:0] id_q;
   logic [7:0] len_q;
   logic [2:0] size_q;
   logic [1:0] burst_q;
   // reset masks the outputs so an abandoned transfer vanishes in the reset cycle itself
   assign in_idle = state == IDLE && !reset;
   assign in_addr = state == ADDR && !reset;
   assign in_data = state == DATA && !reset;
   assign req = s0.arvalid || s1.arvalid;
   assign win1 = s1.arvalid && (!s0.arvalid || (PRIO0 ? starve == 3'(MAXWAIT) : !last_q));
   assign own_rready = grant_q ? s1.rready : s0.rready;
   assign s0_own = in_data && !grant_q;
   assign s1_own = in_data && grant_q;
   always_ff @(posedge clock)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = req ? ADDR : IDLE;
         ADDR:    state_nx = m.arready ? DATA : ADDR;
         DATA:    state_nx = (m.rvalid && own_rready && m.rlast) ? IDLE : DATA;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clock)
      if (reset) begin
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         starve  <= 3'd0;
         addr_q  <= '0;
         id_q    <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
      end else if (state == IDLE) begin
         if (req) begin
            grant_q <= win1;
            last_q  <= win1;
            addr_q  <= win1 ? s1.araddr : s0.araddr;
            id_q    <= win1 ? s1.arid : s0.arid;
            len_q   <= win1 ? s1.arlen : s0.arlen;
            size_q  <= win1 ? s1.arsize : s0.arsize;
            burst_q <= win1 ? s1.arburst : s0.arburst;
         end
         // counts s0 wins over a waiting s1; any idle cycle without s1 pending forgets the streak
         starve <= (win1 || !s1.arvalid) ? 3'd0 : (starve == 3'(MAXWAIT) ? starve : starve + 3'd1);
      end
   assign s0.arready = in_idle && s0.arvalid && !win1;
   assign s1.arready = in_idle && win1;
   assign m.arvalid  = in_addr;
   assign m.araddr   = addr_q;
   assign m.arid     = id_q;
   assign m.arlen    = len_q;
   assign m.arsize   = size_q;
   assign m.arburst  = burst_q;
   assign m.rready   = in_data && own_rready;
   assign s0.rvalid  = s0_own && m.rvalid;
   assign s0.rdata   = s0_own ? m.rdata : '0;
   assign s0.rresp   = s0_own ? m.rresp : '0;
   assign s0.rlast   = s0_own && m.rlast;
   assign s0.rid     = s0_own ? m.rid : '0;
   assign s1.rvalid  = s1_own && m.rvalid;
   assign s1.rdata   = s1_own ? m.rdata : '0;
   assign s1.rresp   = s1_own ? m.rresp : '0;
   assign s1.rlast   = s1_own && m.rlast;
   assign s1.rid     = s1_own ? m.rid : '0;
   assign grant      = grant_q && !reset;
   assign busy       = state != IDLE && !reset;
endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: self-checking bench; a fixed-priority instance gets directed, table and
// random traffic against a transaction-level model, a round-robin instance gets a tie sequence.
module tb_axi_rd_arb;
   localparam int W = 199;
   localparam int MW = 4;
   typedef struct packed {logic v; logic [31:0] a; logic [3:0] id; logic [7:0] len; logic [2:0] sz; logic [1:0] bu;} ar_t;
   typedef struct packed {logic v0; logic v1; logic w;} vec_t;
   logic clk = 1'b0, rst = 1'b1;
   logic grant, busy, rr_grant, rr_busy;
   int n_chk = 0, n_fail = 0;
   axi_rd_arb_if s0(), s1(), m(), s0r(), s1r(), mr();
   axi_rd_arb #(.PRIO0(1'b1), .MAXWAIT(MW)) dut (
      .clock(clk), .reset(rst), .s0(s0), .s1(s1), .m(m), .grant(grant), .busy(busy));
   axi_rd_arb #(.PRIO0(1'b0), .MAXWAIT(MW)) dut_rr (
      .clock(clk), .reset(rst), .s0(s0r), .s1(s1r), .m(mr), .grant(rr_grant), .busy(rr_busy));
   always #5 clk = ~clk;
   int ph, cnt, bi;
   int sbi[2];
   logic own;
   logic acc[2];
   ar_t cap;
   ar_t rq[2];
   ar_t dq[$];
   ar_t sq[2][$];
   vec_t tbl[18];
   function automatic void chk(string nm, logic [255:0] a, logic [255:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endfunction
   function automatic logic [63:0] mem(logic [31:0] a, int i);
      return {a + 32'(i), ~a ^ 32'(i * 7)};
   endfunction
   function automatic logic [W-1:0] obs();
      return {s0.arready, s1.arready, m.arvalid, m.araddr, m.arid, m.arlen, m.arsize, m.arburst, m.rready,
              s0.rvalid, s0.rdata, s0.rresp, s0.rlast, s0.rid,
              s1.rvalid, s1.rdata, s1.rresp, s1.rlast, s1.rid, grant, busy};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // finishes whatever transaction is outstanding with a single-beat response
   task automatic drain();
      int t;
      t = 0;
      m.arready = 1'b1; m.rvalid = 1'b1; m.rlast = 1'b1; s0.rready = 1'b1; s1.rready = 1'b1;
      do begin
         @(negedge clk);
         t++;
      end while (!(m.rvalid && m.rready && m.rlast) && t < 50);
      chk("drain_timeout", t >= 50, 0);
      tick();
      m.arready = 1'b0; m.rvalid = 1'b0; m.rlast = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      int k, t, n, b;
      logic v0, v1, w, ea0, ea1, mrr;
      logic [71:0] rb;
      logic [W-1:0] ex;
      ar_t e;
      {s0.arvalid, s0.araddr, s0.arid, s0.arlen, s0.arsize, s0.arburst, s0.rready} = '0;
      {s1.arvalid, s1.araddr, s1.arid, s1.arlen, s1.arsize, s1.arburst, s1.rready} = '0;
      {s0r.arvalid, s0r.araddr, s0r.arid, s0r.arlen, s0r.arsize, s0r.arburst, s0r.rready} = '0;
      {s1r.arvalid, s1r.araddr, s1r.arid, s1r.arlen, s1r.arsize, s1r.arburst, s1r.rready} = '0;
      {m.arready, m.rvalid, m.rdata, m.rresp, m.rlast, m.rid} = '0;
      {mr.arready, mr.rvalid, mr.rdata, mr.rresp, mr.rlast, mr.rid} = '0;
      tbl = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110,
              3'b111, 3'b110, 3'b100, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b011};
      // reset values, with a stray downstream beat that must not leak through
      tick();
      m.rvalid = 1'b1; m.rdata = 64'hdead_beef_0123_4567; m.rlast = 1'b1;
      @(negedge clk);
      chk("reset_hold", obs(), '0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_after", obs(), '0);
      chk("reset_rr", {rr_busy, rr_grant, s0r.arready, s1r.arready, mr.arvalid, mr.rready}, '0);
      tick();
      m.rvalid = 1'b0; m.rlast = 1'b0;
      // s0 alone: 200-beat burst, AR stalled 10 cycles, owner back-pressure
      s0.arvalid = 1'b1; s0.araddr = 32'h8000_1000; s0.arid = 4'd5; s0.arlen = 8'd199;
      s0.arsize = 3'd3; s0.arburst = 2'd1;
      @(negedge clk);
      chk("cap_pulse", {s0.arready, s1.arready, busy}, 3'b100);
      tick();
      s0.arvalid = 1'b0; s0.araddr = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("ar_hold", {m.arvalid, m.araddr, m.arid, m.arlen, m.arsize, m.arburst, s0.arready, s1.arready},
             {1'b1, 32'h8000_1000, 4'd5, 8'd199, 3'd3, 2'd1, 2'b00});
         tick();
      end
      m.arready = 1'b1;
      tick();
      m.arready = 1'b0;
      k = 0; t = 0;
      while (k < 200 && t < 1000) begin
         s0.rready = ($urandom % 4) != 0;
         m.rvalid = 1'b1; m.rdata = mem(32'h8000_1000, k); m.rlast = k == 199; m.rresp = 2'(k); m.rid = 4'd5;
         @(negedge clk);
         chk("beat", {m.rready, s0.rvalid, s0.rdata, s0.rlast, s0.rresp, s0.rid, s1.rvalid, s1.rdata},
             {s0.rready, 1'b1, mem(32'h8000_1000, k), k == 199, 2'(k), 4'd5, 1'b0, 64'd0});
         if (s0.rready) k++;
         t++;
         tick();
      end
      m.rvalid = 1'b0; m.rlast = 1'b0;
      chk("beats", k, 200);
      @(negedge clk);
      chk("busy_fall", busy, 1'b0);
      tick();
      // fixed-priority grant sequence with starvation relief
      for (int i = 0; i < 18; i++) begin
         s0.arvalid = tbl[i].v0; s1.arvalid = tbl[i].v1;
         s0.araddr = 32'(i); s1.araddr = 32'(i + 100);
         @(negedge clk);
         chk("tbl_win", {s0.arready, s1.arready}, tbl[i].w ? 2'b01 : 2'b10);
         drain();
      end
      s0.arvalid = 1'b0; s1.arvalid = 1'b0;
      // reset at beat 50 of a 200-beat burst, then a fresh s1 request
      s0.arvalid = 1'b1; s0.araddr = 32'h8000_2000; s0.arlen = 8'd199; m.arready = 1'b1; s0.rready = 1'b1;
      tick();
      s0.arvalid = 1'b0;
      m.rvalid = 1'b1; m.rlast = 1'b0;
      k = 0; t = 0;
      while (k < 50 && t < 100) begin
         @(negedge clk);
         if (m.rready) k++;
         t++;
         tick();
      end
      chk("rst_reach50", k, 50);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_during", {busy, grant, m.arvalid, m.rready, s0.arready, s1.arready, s0.rvalid, s1.rvalid}, '0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_after", {busy, grant, m.arvalid, m.rready, s0.rvalid, s1.rvalid, m.araddr, m.arlen}, '0);
      tick();
      m.arready = 1'b0;
      s1.arvalid = 1'b1; s1.araddr = 32'h1234_5000; s1.arid = 4'd9; s1.arlen = 8'd0;
      @(negedge clk);
      chk("rst_s1_cap", {s0.arready, s1.arready}, 2'b01);
      tick();
      s1.arvalid = 1'b0; m.rvalid = 1'b0;
      @(negedge clk);
      chk("rst_s1_ar", {m.arvalid, m.araddr, m.arid, grant, busy}, {1'b1, 32'h1234_5000, 4'd9, 1'b1, 1'b1});
      drain();
      // random traffic against the transaction-level model
      do_reset();
      ph = 0; cnt = 0; bi = 0; own = 1'b0; cap = '0;
      for (int i = 0; i < 2; i++) begin
         rq[i] = '0; acc[i] = 1'b0; sbi[i] = 0; sq[i].delete();
      end
      dq.delete();
      for (int c = 0; c < 4000; c++) begin
         tick();
         for (int i = 0; i < 2; i++)
            if (!rq[i].v || acc[i]) rq[i] = {($urandom % 3) == 0, 32'($urandom), 4'($urandom), 8'($urandom % 8), 3'($urandom), 2'($urandom)};
            else if (($urandom % 16) == 0) rq[i].v = 1'b0;
         {s0.arvalid, s0.araddr, s0.arid, s0.arlen, s0.arsize, s0.arburst} = rq[0];
         {s1.arvalid, s1.araddr, s1.arid, s1.arlen, s1.arsize, s1.arburst} = rq[1];
         s0.rready = ($urandom % 4) != 0;
         s1.rready = ($urandom % 4) != 0;
         m.arready = 1'($urandom);
         if (dq.size() != 0) begin
            m.rvalid = ($urandom % 4) != 0; m.rdata = mem(dq[0].a, bi); m.rlast = bi == int'(dq[0].len);
            m.rid = dq[0].id; m.rresp = 2'($urandom);
         end else begin
            m.rvalid = ($urandom % 8) == 0; m.rdata = {$urandom, $urandom}; m.rlast = 1'($urandom);
            m.rid = 4'($urandom); m.rresp = 2'($urandom);
         end
         @(negedge clk);
         v0 = s0.arvalid; v1 = s1.arvalid;
         w = v1 && (!v0 || cnt == MW);
         ea0 = ph == 0 && v0 && !w;
         ea1 = ph == 0 && w;
         mrr = ph == 2 && (own ? s1.rready : s0.rready);
         rb = {m.rvalid, m.rdata, m.rresp, m.rlast, m.rid};
         ex = {ea0, ea1, ph == 1, cap.a, cap.id, cap.len, cap.sz, cap.bu, mrr,
               (ph == 2 && !own) ? rb : 72'd0, (ph == 2 && own) ? rb : 72'd0, own, ph != 0};
         chk("rand_cycle", obs(), ex);
         if (ea0) sq[0].push_back(rq[0]);
         if (ea1) sq[1].push_back(rq[1]);
         for (int i = 0; i < 2; i++)
            if (i == 0 ? (s0.rvalid && s0.rready) : (s1.rvalid && s1.rready)) begin
               if (sq[i].size() == 0) chk("sb_unexpected", 1, 0);
               else begin
                  e = sq[i][0];
                  chk("sb_beat", i == 0 ? {s0.rdata, s0.rlast, s0.rid} : {s1.rdata, s1.rlast, s1.rid},
                      {mem(e.a, sbi[i]), sbi[i] == int'(e.len), e.id});
                  if (sbi[i] == int'(e.len)) begin
                     void'(sq[i].pop_front());
                     sbi[i] = 0;
                  end else sbi[i]++;
               end
            end
         if (m.arvalid && m.arready) dq.push_back({1'b1, m.araddr, m.arid, m.arlen, m.arsize, m.arburst});
         if (m.rvalid && m.rready && dq.size() != 0) begin
            if (bi == int'(dq[0].len)) begin
               void'(dq.pop_front());
               bi = 0;
            end else bi++;
         end
         acc[0] = s0.arready; acc[1] = s1.arready;
         if (ph == 0 && (v0 || v1)) begin
            cap = w ? rq[1] : rq[0];
            own = w;
            cnt = w ? 0 : (v1 ? (cnt < MW ? cnt + 1 : MW) : 0);
            ph = 1;
         end else if (ph == 0) cnt = 0;
         else if (ph == 1 && m.arready) ph = 2;
         else if (ph == 2 && m.rvalid && mrr && m.rlast) ph = 0;
      end
      chk("rand_progress", (sq[0].size() + sq[1].size()) < 4, 1);
      {s0.arvalid, s1.arvalid, m.arready, m.rvalid} = '0;
      // round-robin instance: continuous ties alternate, 3-beat bursts
      tick();
      s0r.arvalid = 1'b1; s1r.arvalid = 1'b1; s0r.rready = 1'b1; s1r.rready = 1'b1;
      mr.arready = 1'b1; mr.rvalid = 1'b1;
      b = 0; n = 0;
      for (int c = 0; c < 200 && n < 6; c++) begin
         mr.rlast = b == 2;
         @(negedge clk);
         if (s0r.arready || s1r.arready) begin
            chk("rr_grant", {s0r.arready, s1r.arready}, (n % 2) == 1 ? 2'b01 : 2'b10);
            n++;
         end
         if (rr_busy && !rr_grant) chk("rr_s1_quiet", {s1r.rvalid, s1r.rdata}, '0);
         if (mr.rvalid && mr.rready) b = mr.rlast ? 0 : b + 1;
         tick();
      end
      chk("rr_count", n, 6);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
